gemm_tiled_controller: RTL and testbench
========================================

// Module: gemm_tiled_controller
// PURPOSE
//  Loop sequencer for a tiled GeMM engine. Walks M x N x K in tiles of TileM/TileN/TileK
//  (K innermost, then N, then M) and issues tile indices to the operand fetch path.
//  Emits one result beat per (M,N) tile through a valid/ready handshake that backpressures
//  the input stream. Handles non-multiple sizes, zero-size errors and abort.
// PARAMETERS
//  AddrWidth  16  width of size inputs and tile-index outputs
//  TileM      4   rows per tile (>=1)
//  TileN      4   columns per tile (>=1)
//  TileK      4   reduction depth per input beat (>=1)
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          synchronous reset, active-high
//  start_i          in   1          start a job (sampled only in IDLE)
//  abort_i          in   1          cancel current job
//  M_size_i/K_size_i/N_size_i in AddrWidth  matrix sizes in elements, latched on accepted start
//  input_valid_i    in   1          operand beat for current (M,N,K) tile available
//  input_ready_o    out  1          beat accepted when valid & ready
//  M_tile_o/N_tile_o/K_tile_o out AddrWidth  tile indices of the beat being requested
//  first_k_o        out  1          K_tile_o==0 (engine clears accumulator)
//  result_valid_o   out  1          finished (M,N) tile available
//  result_ready_i   in   1          consumer accepts result
//  res_M_tile_o/res_N_tile_o out AddrWidth  tile indices of held result
//  busy_o           out  1          state != IDLE
//  done_o           out  1          one-cycle pulse at normal completion
//  error_o          out  1          one-cycle pulse: start with a zero size
// BEHAVIOUR
//  - Reset (rst_i=1 at clk edge): state IDLE; all counters, indices, result_valid_o,
//    input_ready_o, busy_o, done_o, error_o = 0. Reset overrides everything incl. mid-job.
//  - Tile counts latched at start: Mt=ceil(M/TileM), Nt=ceil(N/TileN), Kt=ceil(K/TileK);
//    computed in AddrWidth+1 bits, no overflow at size=2^AddrWidth-1.
//  - States: IDLE -> (start, all sizes!=0) BUSY; IDLE -> (start, any size==0) stays IDLE,
//    error_o=1 for 1 cycle. BUSY -> DRAIN after last beat (m=Mt-1,n=Nt-1,k=Kt-1) accepted.
//    DRAIN -> DONE when final result handshakes. DONE -> IDLE, done_o=1 in DONE only.
//  - start_i outside IDLE ignored. abort_i in BUSY/DRAIN/DONE: next state IDLE, counters
//    cleared, result_valid_o dropped, no done_o; abort has priority over start/handshakes.
//  - input_ready_o = (state==BUSY) & ~(k==Kt-1 & result_valid_o & ~result_ready_i).
//    Combinational from result_ready_i; stalls only the beat that would create a second
//    pending result. No beat accepted outside BUSY.
//  - Accepted beat: k++; at k==Kt-1 wrap k=0, n++; at n==Nt-1 wrap n=0, m++.
//    Indices update the cycle after acceptance; first_k_o combinational from k.
//  - Last-K beat accepted: result register loads (m,n) of that beat, result_valid_o=1 next
//    cycle, held stable until result_ready_i. Simultaneous accept-old/load-new in same cycle
//    allowed (back-to-back results when Kt==1). Latency last-K accept -> result_valid_o: 1.
// CONFIGURATION
//  GEMM_CTRL_PERF_EN defined: extra outputs perf_cycles_o[31:0] (cycles in BUSY/DRAIN)
//    and perf_stalls_o[31:0] (BUSY cycles with input_valid_i & ~input_ready_o); cleared
//    on accepted start and reset, saturate at 2^32-1, hold after done.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Tiles 4/4/4, M=8,K=8,N=4, valid=1, ready=1 -> 4 beats (m,n,k)=(0,0,0),(0,0,1),
//    (1,0,0),(1,0,1); results (0,0),(1,0); done_o 1 cycle; busy_o low next cycle.
//  2 M=5,K=3,N=9 -> Mt=2,Kt=1,Nt=3: 6 beats, 6 back-to-back results (0,0)..(1,2), no stall.
//  3 Test 2 with result_ready_i=0 for 5 cycles after first result -> input_ready_o low
//    while pending, result held stable, no beat or result lost/duplicated.
//  4 start with K=0 -> error_o 1 cycle, busy_o=0, no beats, no done_o.
//  5 abort_i after 3 beats of test 1 -> IDLE next cycle, result_valid_o=0, no done_o;
//    new start runs test 1 fully correct.
//  6 rst_i mid-DRAIN -> all outputs 0 next cycle; with GEMM_CTRL_PERF_EN, test 3
//    reports perf_stalls_o=5.

Source files
------------

// File: rtl/gemm_tiled_controller.sv
// Tiled GeMM loop sequencer: walks M x N x K tiles (K innermost) and emits one result per (M,N) tile.
// Optional GEMM_CTRL_PERF_EN adds perf_cycles_o / perf_stalls_o counters.
//   state | meaning
//   IDLE  | waiting for start_i
//   BUSY  | issuing operand beats
//   DRAIN | last beat taken, waiting for final result handshake
//   DONE  | one-cycle completion, done_o pulses
module gemm_tiled_controller #(
    parameter int AddrWidth = 16,
    parameter int TileM     = 4,
    parameter int TileN     = 4,
    parameter int TileK     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic                 input_valid_i,
    output logic                 input_ready_o,
    output logic [AddrWidth-1:0] M_tile_o,
    output logic [AddrWidth-1:0] N_tile_o,
    output logic [AddrWidth-1:0] K_tile_o,
    output logic                 first_k_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [AddrWidth-1:0] res_M_tile_o,
    output logic [AddrWidth-1:0] res_N_tile_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
`ifdef GEMM_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles_o,
    output logic [31:0]          perf_stalls_o
`endif
);

    localparam int CntW = AddrWidth + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
    logic [AddrWidth-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
    logic [AddrWidth-1:0] res_m_q, res_m_d, res_n_q, res_n_d;
    logic                 res_valid_q, res_valid_d;
    logic                 err_q, err_d;
    logic                 last_k, last_n, last_m, accept;

    // Sizes are widened by one bit so the ceil round-up cannot overflow at the max size.
    function automatic logic [CntW-1:0] ceil_div(input logic [AddrWidth-1:0] size, input int tile);
        return ({1'b0, size} + CntW'(tile - 1)) / CntW'(tile);
    endfunction

    assign last_k = ({1'b0, k_q} == kt_q - CntW'(1));
    assign last_n = ({1'b0, n_q} == nt_q - CntW'(1));
    assign last_m = ({1'b0, m_q} == mt_q - CntW'(1));

    assign input_ready_o  = (state_q == BUSY) & ~(last_k & res_valid_q & ~result_ready_i);
    assign accept         = input_valid_i & input_ready_o & ~abort_i;
    assign M_tile_o       = m_q;
    assign N_tile_o       = n_q;
    assign K_tile_o       = k_q;
    assign first_k_o      = (k_q == '0);
    assign result_valid_o = res_valid_q;
    assign res_M_tile_o   = res_m_q;
    assign res_N_tile_o   = res_n_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE) & ~abort_i;
    assign error_o        = err_q;

`ifdef GEMM_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;
    assign perf_cycles_o = perf_cycles_q;
    assign perf_stalls_o = perf_stalls_q;
`endif

    always_comb begin
        state_d     = state_q;
        mt_d        = mt_q;
        nt_d        = nt_q;
        kt_d        = kt_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        res_m_d     = res_m_q;
        res_n_d     = res_n_q;
        res_valid_d = res_valid_q;
        err_d       = 1'b0;
`ifdef GEMM_CTRL_PERF_EN
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if ((state_q == BUSY || state_q == DRAIN) && perf_cycles_q != 32'hFFFF_FFFF)
            perf_cycles_d = perf_cycles_q + 32'd1;
        if (state_q == BUSY && input_valid_i && !input_ready_o && perf_stalls_q != 32'hFFFF_FFFF)
            perf_stalls_d = perf_stalls_q + 32'd1;
`endif

        // Release happens before a possible load so accept-old/load-new can share a cycle.
        if (res_valid_q && result_ready_i)
            res_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        mt_d    = ceil_div(M_size_i, TileM);
                        nt_d    = ceil_div(N_size_i, TileN);
                        kt_d    = ceil_div(K_size_i, TileK);
                        m_d     = '0;
                        n_d     = '0;
                        k_d     = '0;
                        state_d = BUSY;
`ifdef GEMM_CTRL_PERF_EN
                        perf_cycles_d = '0;
                        perf_stalls_d = '0;
`endif
                    end
                end
            end
            BUSY: begin
                if (accept) begin
                    if (last_k) begin
                        res_m_d     = m_q;
                        res_n_d     = n_q;
                        res_valid_d = 1'b1;
                        k_d         = '0;
                        if (last_n) begin
                            n_d = '0;
                            if (last_m) begin
                                m_d     = '0;
                                state_d = DRAIN;
                            end else begin
                                m_d = m_q + AddrWidth'(1);
                            end
                        end else begin
                            n_d = n_q + AddrWidth'(1);
                        end
                    end else begin
                        k_d = k_q + AddrWidth'(1);
                    end
                end
            end
            DRAIN: begin
                if (res_valid_q && result_ready_i)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_i && state_q != IDLE) begin
            state_d     = IDLE;
            m_d         = '0;
            n_d         = '0;
            k_d         = '0;
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mt_q        <= '0;
            nt_q        <= '0;
            kt_q        <= '0;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            res_m_q     <= '0;
            res_n_q     <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mt_q        <= mt_d;
            nt_q        <= nt_d;
            kt_q        <= kt_d;
            m_q         <= m_d;
            n_q         <= n_d;
            k_q         <= k_d;
            res_m_q     <= res_m_d;
            res_n_q     <= res_n_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

`ifdef GEMM_CTRL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end
`endif

endmodule

// File: tb/tb_gemm_tiled_controller.sv
// Scoreboard bench for gemm_tiled_controller: a nested-loop tile model fills expectation queues,
// a negedge monitor pops and compares on every beat/result handshake.
module tb_gemm_tiled_controller;

    localparam int AW = 16;
    localparam int TM = 4;
    localparam int TN = 4;
    localparam int TK = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] M_size_i = '0;
    logic [AW-1:0] K_size_i = '0;
    logic [AW-1:0] N_size_i = '0;
    logic          input_valid_i = 1'b0;
    logic          input_ready_o;
    logic [AW-1:0] M_tile_o, N_tile_o, K_tile_o;
    logic          first_k_o;
    logic          result_valid_o;
    logic          result_ready_i = 1'b0;
    logic [AW-1:0] res_M_tile_o, res_N_tile_o;
    logic          busy_o, done_o, error_o;
`ifdef GEMM_CTRL_PERF_EN
    logic [31:0]   perf_cycles_o, perf_stalls_o;
`endif

    gemm_tiled_controller #(.AddrWidth(AW), .TileM(TM), .TileN(TN), .TileK(TK)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
        .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
        .M_tile_o(M_tile_o), .N_tile_o(N_tile_o), .K_tile_o(K_tile_o),
        .first_k_o(first_k_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .res_M_tile_o(res_M_tile_o), .res_N_tile_o(res_N_tile_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
`ifdef GEMM_CTRL_PERF_EN
        , .perf_cycles_o(perf_cycles_o), .perf_stalls_o(perf_stalls_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int m; int n; int k; } beat_t;
    typedef struct { int m; int n; } res_t;

    beat_t exp_beats[$];
    res_t  exp_res[$];

    int tests = 0;
    int fails = 0;
    int beat_cnt = 0;
    int res_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int stall_cnt = 0;
    int busy_cyc = 0;
    bit hold_pend = 0;
    int hold_m, hold_n;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            // outputs are checked directly by the reset sequence
        end else if (abort_i) begin
            hold_pend = 0;
        end else begin
            if (input_valid_i && input_ready_o) begin
                beat_cnt++;
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_m", int'(M_tile_o), b.m);
                    check("beat_n", int'(N_tile_o), b.n);
                    check("beat_k", int'(K_tile_o), b.k);
                    check("first_k", int'(first_k_o), int'(b.k == 0));
                end
            end
            if (busy_o && input_valid_i && !input_ready_o) stall_cnt++;
            if (busy_o && !done_o) busy_cyc++;
            if (result_valid_o) begin
                if (hold_pend) begin
                    check("held_res_m", int'(res_M_tile_o), hold_m);
                    check("held_res_n", int'(res_N_tile_o), hold_n);
                end
                if (result_ready_i) begin
                    hold_pend = 0;
                    res_cnt++;
                    if (exp_res.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        res_t r;
                        r = exp_res.pop_front();
                        check("res_m", int'(res_M_tile_o), r.m);
                        check("res_n", int'(res_N_tile_o), r.n);
                    end
                end else begin
                    hold_pend = 1;
                    hold_m = int'(res_M_tile_o);
                    hold_n = int'(res_N_tile_o);
                end
            end else if (hold_pend) begin
                check("result_dropped", 0, 1);
                hold_pend = 0;
            end
            if (done_o) done_cnt++;
            if (error_o) err_cnt++;
        end
    end

    // Reference: plain nested loops over ceil-divided tile counts, K innermost.
    task automatic model_job(input int ms, input int ks, input int ns, output int tot);
        int mt, nt, kt;
        mt = (ms + TM - 1) / TM;
        nt = (ns + TN - 1) / TN;
        kt = (ks + TK - 1) / TK;
        tot = mt * nt * kt;
        for (int mi = 0; mi < mt; mi++)
            for (int ni = 0; ni < nt; ni++)
                for (int ki = 0; ki < kt; ki++) begin
                    beat_t b;
                    b.m = mi; b.n = ni; b.k = ki;
                    exp_beats.push_back(b);
                    if (ki == kt - 1) begin
                        res_t r;
                        r.m = mi; r.n = ni;
                        exp_res.push_back(r);
                    end
                end
    endtask

    task automatic issue_start(input int ms, input int ks, input int ns);
        @(posedge clk_i); #1;
        M_size_i = ms[AW-1:0];
        K_size_i = ks[AW-1:0];
        N_size_i = ns[AW-1:0];
        start_i = 1'b1;
        input_valid_i = 1'b0;
        result_ready_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic run_job(input int ms, input int ks, input int ns, input int vpct,
                           input int rpct, input bit hold5, input int max_cyc);
        int tot, b0, r0, d0, cyc, hold_used;
        model_job(ms, ks, ns, tot);
        issue_start(ms, ks, ns);
        check("busy_after_start", int'(busy_o), 1);
        b0 = beat_cnt; r0 = res_cnt; d0 = done_cnt;
        stall_cnt = 0; busy_cyc = 0; cyc = 0; hold_used = 0;
        while (done_cnt == d0 && cyc < max_cyc) begin
            input_valid_i = (beat_cnt - b0 < tot) && ($urandom_range(99) < vpct);
            if (hold5 && result_valid_o && hold_used < 5) begin
                result_ready_i = 1'b0;
                hold_used++;
            end else begin
                result_ready_i = ($urandom_range(99) < rpct);
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        input_valid_i = 1'b0;
        result_ready_i = 1'b0;
        check("job_timeout", int'(cyc < max_cyc), 1);
        check("done_one_cycle", int'(done_o), 0);
        check("busy_after_done", int'(busy_o), 0);
        check("beats_total", beat_cnt - b0, tot);
        check("results_total", res_cnt - r0, tot / ((ks + TK - 1) / TK));
        check("beats_left", exp_beats.size(), 0);
        check("results_left", exp_res.size(), 0);
    endtask

    initial begin
        int b0, d0, e0, cyc, tot;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_in_ready", int'(input_ready_o), 0);
        check("rst_res_valid", int'(result_valid_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_error", int'(error_o), 0);
        rst_i = 1'b0;

        // Test 1: two M tiles, two K tiles, always ready.
        run_job(8, 8, 4, 100, 100, 0, 200);
        check("t1_stalls", stall_cnt, 0);

        // Test 2: Kt=1 back-to-back results, no stall.
        run_job(5, 3, 9, 100, 100, 0, 200);
        check("t2_stalls", stall_cnt, 0);

        // Test 3: consumer withholds first result for 5 cycles.
        run_job(5, 3, 9, 100, 100, 1, 200);
        check("t3_stalls", stall_cnt, 5);
`ifdef GEMM_CTRL_PERF_EN
        check("t3_perf_stalls", int'(perf_stalls_o), 5);
        check("t3_perf_cycles", int'(perf_cycles_o), busy_cyc);
`endif

        // Test 4: zero size -> error pulse only.
        b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
        issue_start(4, 0, 4);
        check("err_pulse", int'(error_o), 1);
        check("err_busy", int'(busy_o), 0);
        input_valid_i = 1'b1;
        @(posedge clk_i); #1;
        check("err_one_cycle", int'(error_o), 0);
        @(posedge clk_i); #1;
        input_valid_i = 1'b0;
        check("err_count", err_cnt - e0, 1);
        check("err_no_beats", beat_cnt - b0, 0);
        check("err_no_done", done_cnt - d0, 0);

        // Test 5: abort after 3 beats of test 1, then rerun it.
        model_job(8, 8, 4, tot);
        issue_start(8, 8, 4);
        b0 = beat_cnt; d0 = done_cnt; cyc = 0;
        input_valid_i = 1'b1;
        result_ready_i = 1'b1;
        while (beat_cnt - b0 < 3 && cyc < 50) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        check("abort_wait", int'(cyc < 50), 1);
        input_valid_i = 1'b0;
        abort_i = 1'b1;
        check("abort_no_done_pulse", int'(done_o), 0);
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        result_ready_i = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_res_valid", int'(result_valid_o), 0);
        check("abort_in_ready", int'(input_ready_o), 0);
        check("abort_beats", beat_cnt - b0, 3);
        exp_beats.delete();
        exp_res.delete();
        repeat (2) @(posedge clk_i);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        run_job(8, 8, 4, 100, 100, 0, 200);

        // Test 6: reset while a result is pending in DRAIN.
        model_job(4, 4, 4, tot);
        issue_start(4, 4, 4);
        b0 = beat_cnt; cyc = 0;
        input_valid_i = 1'b1;
        result_ready_i = 1'b0;
        while (beat_cnt == b0 && cyc < 20) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        input_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("drain_pending", int'(result_valid_o), 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_mid_busy", int'(busy_o), 0);
        check("rst_mid_res_valid", int'(result_valid_o), 0);
        check("rst_mid_in_ready", int'(input_ready_o), 0);
        check("rst_mid_done", int'(done_o), 0);
        check("rst_mid_error", int'(error_o), 0);
        check("rst_mid_res_m", int'(res_M_tile_o), 0);
        check("rst_mid_k", int'(K_tile_o), 0);
        hold_pend = 0;
        exp_beats.delete();
        exp_res.delete();
        rst_i = 1'b0;

        // Randomized jobs with random flow control on both sides.
        for (int j = 0; j < 20; j++) begin
            run_job(int'($urandom_range(13, 1)), int'($urandom_range(13, 1)),
                    int'($urandom_range(13, 1)), int'($urandom_range(100, 40)),
                    int'($urandom_range(100, 40)), 0, 3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
